// File: rtl/mmio_test_monitor_pkg.sv
// rtl/mmio_test_monitor_pkg.sv - shared register map, ID constant, state encoding
package mmio_test_monitor_pkg;

  localparam logic [11:0] OFF_ID     = 12'h000;
  localparam logic [11:0] OFF_CYCLE  = 12'h004;
  localparam logic [11:0] OFF_STATUS = 12'h008;
  localparam logic [11:0] OFF_DONE   = 12'h00C;
  localparam logic [11:0] OFF_LOG0   = 12'h010;

  localparam logic [31:0] ID_VALUE = 32'h5359_4E31;

  typedef enum logic [1:0] {
    ST_RUNNING = 2'd0,
    ST_PASSED  = 2'd1,
    ST_FAILED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam int STATUS_DONE_BIT     = 0;
  localparam int STATUS_PASS_BIT     = 1;
  localparam int STATUS_TIMEOUT_BIT  = 2;
  localparam int STATUS_OVERFLOW_BIT = 3;
  localparam int STATUS_OCC_LSB      = 8;

endpackage

// File: rtl/mmio_test_monitor_log_fifo.sv
// rtl/mmio_test_monitor_log_fifo.sv - synchronous FIFO buffering log entries
// A push while full is accepted only when a pop happens in the same cycle.
module log_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mmio_test_monitor.sv
// rtl/mmio_test_monitor.sv - memory-mapped pass/fail, log console and watchdog peripheral
module mmio_test_monitor
  import mmio_test_monitor_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0200_0000,
  parameter int          DATA_WIDTH   = 32,
  parameter int          NUM_CHANNELS = 4,
  parameter int          LOG_DEPTH    = 8,
  parameter int          MAX_CYCLES   = 10000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_write,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  log_valid,
  input  logic                  log_ready,
  output logic [3:0]            log_channel,
  output logic [DATA_WIDTH-1:0] log_data,
  output logic                  done,
  output logic                  pass,
  output logic [DATA_WIDTH-1:0] fail_code,
  output logic                  timeout,
  output logic                  overflow,
  output logic [31:0]           cycle_count
);

  localparam int CW = $clog2(LOG_DEPTH) + 1;
  localparam int EW = DATA_WIDTH + 4;

  state_e                state_q;
  logic                  done_q, pass_q, timeout_q, overflow_q;
  logic [DATA_WIDTH-1:0] fail_code_q;
  logic [31:0]           cycle_q;

  logic                  in_window, done_wr, log_wr, timeout_hit;
  logic [9:0]            word_off, log_word;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0]         fifo_count;
  logic [EW-1:0]         fifo_head;
  logic [31:0]           status_word;

  assign in_window = (addr[31:12] == BASE_ADDR[31:12]) && (addr[1:0] == 2'b00);
  assign word_off  = addr[11:2];
  assign log_word  = word_off - OFF_LOG0[11:2];
  assign done_wr   = mem_write && in_window && (word_off == OFF_DONE[11:2]);
  assign log_wr    = mem_write && in_window && (state_q == ST_RUNNING)
                   && (word_off >= OFF_LOG0[11:2]) && (log_word < 10'(NUM_CHANNELS));

  assign timeout_hit = (MAX_CYCLES != 0) && (cycle_q == 32'(MAX_CYCLES - 1));

  // Cycle counter only advances on edges that leave the monitor in RUNNING,
  // so it reads the cycle of the terminating event afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUNNING;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_code_q <= '0;
      cycle_q     <= '0;
    end else if (state_q == ST_RUNNING) begin
      if (done_wr && wdata == DATA_WIDTH'(1)) begin
        state_q <= ST_PASSED;
        done_q  <= 1'b1;
        pass_q  <= 1'b1;
      end else if (done_wr && wdata != '0) begin
        state_q     <= ST_FAILED;
        done_q      <= 1'b1;
        fail_code_q <= wdata;
      end else if (timeout_hit) begin
        state_q     <= ST_TIMEOUT;
        done_q      <= 1'b1;
        timeout_q   <= 1'b1;
        fail_code_q <= DATA_WIDTH'(MAX_CYCLES);
      end else if (cycle_q != 32'hFFFF_FFFF) begin
        cycle_q <= cycle_q + 32'd1;
      end
    end
  end

  assign fifo_pop = !fifo_empty && log_ready;

  always_ff @(posedge clk) begin
    if (reset) overflow_q <= 1'b0;
    else if (log_wr && fifo_full && !fifo_pop) overflow_q <= 1'b1;
  end

  log_fifo #(
    .WIDTH (EW),
    .DEPTH (LOG_DEPTH)
  ) u_log_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (log_wr),
    .pop_i   (fifo_pop),
    .data_i  ({log_word[3:0], wdata}),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    status_word = '0;
    status_word[STATUS_DONE_BIT]     = done_q;
    status_word[STATUS_PASS_BIT]     = pass_q;
    status_word[STATUS_TIMEOUT_BIT]  = timeout_q;
    status_word[STATUS_OVERFLOW_BIT] = overflow_q;
    status_word[STATUS_OCC_LSB +: 8] = 8'(fifo_count);
  end

  always_comb begin
    rdata = '0;
    if (in_window) begin
      if (word_off == OFF_ID[11:2])          rdata = DATA_WIDTH'(ID_VALUE);
      else if (word_off == OFF_CYCLE[11:2])  rdata = DATA_WIDTH'(cycle_q);
      else if (word_off == OFF_STATUS[11:2]) rdata = DATA_WIDTH'(status_word);
    end
  end

  assign log_valid   = !fifo_empty;
  assign log_channel = fifo_head[EW-1 -: 4];
  assign log_data    = fifo_head[DATA_WIDTH-1:0];
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign fail_code   = fail_code_q;
  assign overflow    = overflow_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_mmio_test_monitor.sv
// tb/tb_mmio_test_monitor.sv - self-checking bench for mmio_test_monitor
module tb_mmio_test_monitor;

  localparam int MAXC  = 50;
  localparam int DEPTH = 8;
  localparam int NCH   = 4;
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        log_valid;
  logic        log_ready = 1'b0;
  logic [3:0]  log_channel;
  logic [31:0] log_data;
  logic        done, pass, timeout, overflow;
  logic [31:0] fail_code, cycle_count;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mmio_test_monitor #(
    .BASE_ADDR    (BASE),
    .DATA_WIDTH   (32),
    .NUM_CHANNELS (NCH),
    .LOG_DEPTH    (DEPTH),
    .MAX_CYCLES   (MAXC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_write   (mem_write),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .log_valid   (log_valid),
    .log_ready   (log_ready),
    .log_channel (log_channel),
    .log_data    (log_data),
    .done        (done),
    .pass        (pass),
    .fail_code   (fail_code),
    .timeout     (timeout),
    .overflow    (overflow),
    .cycle_count (cycle_count)
  );

  typedef struct {
    logic [3:0]  ch;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  bit          m_done, m_pass, m_to, m_ovf;
  logic [31:0] m_fail, m_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:12] != BASE[31:12]) return 32'h0;
    case (a[11:0])
      12'h000: return 32'h5359_4E31;
      12'h004: return m_cyc;
      12'h008: return {16'h0, 8'(mq.size()), 4'h0, m_ovf, m_to, m_pass, m_done};
      default: return 32'h0;
    endcase
  endfunction

  // Reference model: applies the register-map rules to what the bus presented at each edge.
  always @(posedge clk) begin
    bit          running, inwin;
    logic [11:0] off;
    if (reset) begin
      m_done = 0; m_pass = 0; m_to = 0; m_ovf = 0; m_fail = 0; m_cyc = 0;
      mq.delete();
    end else begin
      running = !m_done;
      inwin   = (addr[31:12] == BASE[31:12]);
      off     = addr[11:0];
      if (mq.size() > 0 && log_ready) void'(mq.pop_front());
      if (mem_write && inwin && running && off >= 12'h010
          && off < 12'(16 + 4 * NCH) && off[1:0] == 2'b00) begin
        if (mq.size() < DEPTH) mq.push_back('{ch: 4'((off - 12'h010) / 4), d: wdata});
        else m_ovf = 1;
      end
      if (running) begin
        if (mem_write && inwin && off == 12'h00C && wdata == 32'd1) begin
          m_done = 1; m_pass = 1;
        end else if (mem_write && inwin && off == 12'h00C && wdata != 32'd0) begin
          m_done = 1; m_fail = wdata;
        end else if (m_cyc == 32'(MAXC - 1)) begin
          m_done = 1; m_to = 1; m_fail = 32'(MAXC);
        end
        if (!m_done && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("log_valid", 32'(log_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("log_channel", 32'(log_channel), 32'(mq[0].ch));
        chk("log_data", log_data, mq[0].d);
      end
      chk("done", 32'(done), 32'(m_done));
      chk("pass", 32'(pass), 32'(m_pass));
      chk("timeout", 32'(timeout), 32'(m_to));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("fail_code", fail_code, m_fail);
      chk("cycle_count", cycle_count, m_cyc);
      chk("rdata", rdata, model_read(addr));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1; addr = a; wdata = d;
    cyc();
    mem_write = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_write = 1'b0; log_ready = 1'b0; addr = '0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a, input string name, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  initial begin
    cyc(); cyc();
    chk_en = 1'b1;
    reset = 1'b0;

    // pass at cycle 20, later DONE writes ignored
    do_reset();
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cycle", cycle_count, 32'd0);
    repeat (20) cyc();
    wr(BASE + 32'h0C, 32'd1);
    chk("t1_pass", 32'(pass), 32'd1);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_cycle", cycle_count, 32'd20);
    wr(BASE + 32'h0C, 32'd5);
    chk("t1_pass_hold", 32'(pass), 32'd1);
    chk("t1_fail_zero", fail_code, 32'd0);
    cyc();
    chk("t1_cycle_frozen", cycle_count, 32'd20);

    // fail code
    do_reset();
    repeat (3) cyc();
    wr(BASE + 32'h0C, 32'd0);
    chk("t2_zero_noop", 32'(done), 32'd0);
    wr(BASE + 32'h0C, 32'h0000_DEAD);
    chk("t2_fail_code", fail_code, 32'h0000_DEAD);
    chk("t2_pass", 32'(pass), 32'd0);
    peek(BASE + 32'h08, "t2_status", 32'h0000_0001);

    // watchdog timeout
    do_reset();
    repeat (49) cyc();
    chk("t3_no_to_yet", 32'(timeout), 32'd0);
    chk("t3_cycle49", cycle_count, 32'd49);
    cyc();
    chk("t3_timeout", 32'(timeout), 32'd1);
    chk("t3_fail50", fail_code, 32'd50);
    chk("t3_done", 32'(done), 32'd1);

    // DONE write at cycle 49 wins over the watchdog
    do_reset();
    repeat (49) cyc();
    wr(BASE + 32'h0C, 32'd1);
    chk("t3b_pass", 32'(pass), 32'd1);
    chk("t3b_no_to", 32'(timeout), 32'd0);

    // two channels queued then drained in order; invalid addresses ignored
    do_reset();
    wr(BASE + 32'h10, 32'h11);
    chk("t4_latency", 32'(log_valid), 32'd1);
    wr(BASE + 32'h18, 32'h22);
    wr(BASE + 32'h20, 32'h33);
    wr(32'h0300_0010, 32'h44);
    peek(BASE + 32'h08, "t4_occ2", 32'h0000_0200);
    log_ready = 1'b1;
    #1;
    chk("t4_head0_ch", 32'(log_channel), 32'd0);
    chk("t4_head0_d", log_data, 32'h11);
    cyc();
    chk("t4_head1_ch", 32'(log_channel), 32'd2);
    chk("t4_head1_d", log_data, 32'h22);
    cyc();
    chk("t4_empty", 32'(log_valid), 32'd0);

    // overflow, then full push with simultaneous pop
    do_reset();
    for (int i = 0; i < 9; i++) wr(BASE + 32'h14, 32'(i + 100));
    peek(BASE + 32'h08, "t5_full_ovf", 32'h0000_0808);
    chk("t5_overflow", 32'(overflow), 32'd1);
    do_reset();
    for (int i = 0; i < 8; i++) wr(BASE + 32'h14, 32'(i + 200));
    log_ready = 1'b1;
    wr(BASE + 32'h14, 32'd300);
    log_ready = 1'b0;
    peek(BASE + 32'h08, "t5_push_pop", 32'h0000_0800);
    chk("t5_no_ovf", 32'(overflow), 32'd0);
    chk("t5_head", log_data, 32'd201);
    log_ready = 1'b1;
    repeat (10) cyc();
    log_ready = 1'b0;

    // reset mid-drain in PASSED
    do_reset();
    for (int i = 0; i < 3; i++) wr(BASE + 32'h1C, 32'(i + 7));
    wr(BASE + 32'h0C, 32'd1);
    wr(BASE + 32'h10, 32'h99);
    peek(BASE + 32'h08, "t6_before", 32'h0000_0303);
    reset = 1'b1;
    cyc();
    chk("t6_valid", 32'(log_valid), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_cycle", cycle_count, 32'd0);
    peek(BASE + 32'h08, "t6_status", 32'h0000_0000);
    peek(BASE, "t6_id", 32'h5359_4E31);
    reset = 1'b0;
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_test_monitor.md
Name: mmio_test_monitor

Overview:
- Synthesisable, memory-mapped test-status and console peripheral on the core's data bus, decoded beside data memory at BASE_ADDR.
- Captures pass/fail completion writes and buffers multi-channel log writes in a FIFO, drained by a valid/ready sink such as a bench printer or UART.
- Runs a watchdog cycle counter that declares timeout.
- Generalises the bench-only "write 1 to 0x0200000C ends the run, higher addresses print values" convention into hardware with fail codes, N log channels, buffering, overflow tracking and a timeout.

Parameters:
- BASE_ADDR, 32'h0200_0000, base of the 4 KiB-aligned register window.
- DATA_WIDTH, 32, bus data width and log payload width.
- NUM_CHANNELS, 4, number of log channel registers (1..16).
- LOG_DEPTH, 8, FIFO entries (power of two, at least 2).
- MAX_CYCLES, 10000, watchdog limit in clk cycles; 0 disables the watchdog.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high reset.
- mem_write, input, 1, bus write strobe for the current cycle.
- addr, input, 32, byte address, word aligned.
- wdata, input, DATA_WIDTH, write data.
- rdata, output, DATA_WIDTH, combinational read data for addr; 0 when addr is outside the window.
- log_valid, output, 1, FIFO head is valid.
- log_ready, input, 1, sink accepts the head entry.
- log_channel, output, 4, channel index of the head entry.
- log_data, output, DATA_WIDTH, payload of the head entry.
- done, output, 1, high in any terminal state.
- pass, output, 1, high only in PASSED.
- fail_code, output, DATA_WIDTH, code latched on failure; holds MAX_CYCLES in TIMEOUT.
- timeout, output, 1, high only in TIMEOUT.
- overflow, output, 1, sticky: a log write was dropped.
- cycle_count, output, 32, cycles since reset.

Behaviour:
- Register map (offsets from BASE_ADDR):
  - 0x00 ID, read-only, reads 32'h5359_4E31.
  - 0x04 CYCLE, read-only, returns cycle_count.
  - 0x08 STATUS, read-only: bit0 done, bit1 pass, bit2 timeout, bit3 overflow; bits[15:8] FIFO occupancy.
  - 0x0C DONE, write-only, reads 0.
  - 0x10 + 4*k, write-only, log channel k for k < NUM_CHANNELS.
  - Writes to any other offset are ignored.
- Reset (synchronous): state RUNNING; cycle_count 0; FIFO empty; log_valid 0; overflow 0; fail_code 0; done, pass and timeout 0.
- State machine, one update per clk, reset returns to RUNNING from any state:
  - RUNNING -> PASSED on a DONE write with wdata == 1.
  - RUNNING -> FAILED on a DONE write with wdata != 1 and wdata != 0; fail_code latches wdata.
  - A DONE write of 0 is a no-op.
  - RUNNING -> TIMEOUT when MAX_CYCLES != 0 and cycle_count == MAX_CYCLES-1; fail_code becomes MAX_CYCLES.
  - If a DONE write and the timeout fire in the same cycle, the DONE write wins.
  - PASSED, FAILED and TIMEOUT are terminal; later DONE writes are ignored.
- done, pass, timeout and fail_code are registered; they update on the clk edge that samples the triggering write.
- cycle_count increments every cycle in RUNNING, freezes in terminal states, and saturates at 32'hFFFF_FFFF.
- Log write in RUNNING:
  - Pushes {k, wdata[DATA_WIDTH-1:0]}.
  - The entry is visible on log_valid the next cycle when the FIFO was empty (1-cycle latency).
  - Log writes in terminal states are dropped without setting overflow.
  - Entries already queued keep draining after a terminal state.
- Pop occurs when log_valid && log_ready. log_channel and log_data are stable while log_valid is high and log_ready is low.
- Full FIFO:
  - A push with no pop in the same cycle is dropped and sets overflow (sticky until reset).
  - A push and pop in the same cycle are both performed; occupancy is unchanged and overflow is not set.
- Empty FIFO: log_valid is 0; log_ready is ignored. Pointers wrap modulo LOG_DEPTH.
- Occupancy counter width is clog2(LOG_DEPTH)+1 and reaches LOG_DEPTH exactly; the STATUS field is zero-extended.
- Reset asserted mid-drain discards all queued entries.

Decomposition:
- Shared package mmio_test_monitor_pkg holds:
  - register offsets (ID, CYCLE, STATUS, DONE, LOG0);
  - the ID constant;
  - state encoding: RUNNING=2'd0, PASSED=2'd1, FAILED=2'd2, TIMEOUT=2'd3;
  - STATUS bit positions.
- One sub-module, log_fifo: synchronous FIFO parametrised by width and depth, exposing push, pop, full, empty and count.
- Address decode, state machine and counter stay in the top module.

Test Plan:
- Reset, then write 1 to 0x0200000C at cycle 20 -> done=1 and pass=1 next cycle; cycle_count frozen at 20; a later write of 5 to 0x0C leaves pass=1 and fail_code=0.
- Write 0xDEAD to 0x0200000C -> done=1, pass=0, fail_code=0xDEAD; a read of 0x02000008 returns bit0=1 and bit1=0.
- MAX_CYCLES=50 with no writes -> timeout=1 after cycle 49, fail_code=50, done=1. In a separate run, write 1 to DONE exactly at cycle 49 -> pass=1, timeout=0.
- log_ready=0, writes 0x11 to 0x10 and 0x22 to 0x18 -> STATUS occupancy 2. Then raise log_ready -> outputs in order (ch0, 0x11), then (ch2, 0x22); log_valid drops afterwards.
- LOG_DEPTH=8, log_ready=0, 9 writes to 0x14 -> 8 entries queued, overflow=1. Refill to full, then push while log_ready=1 -> occupancy stays 8 and overflow does not newly assert after a reset.
- Assert reset with 3 entries queued and state PASSED -> next cycle log_valid=0, occupancy 0, done=0, cycle_count=0, and reading 0x02000000 returns 0x53594E31.
